// File: rtl/mic_capture_pkg.sv
// rtl/mic_capture_pkg.sv - shared audio constants, ADC reader state type and helpers
package mic_capture_pkg;

    localparam int          MIC_FRAME_BITS = 16;
    localparam int          MIC_DATA_BITS  = 12;
    localparam logic [11:0] AUDIO_MIDSCALE = 12'h800;
    localparam int          LEVEL_MAX      = 9;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        QUIET
    } mic_state_e;

    // Distance from mid-scale. Twelve bits, so the full negative swing (2048) fits.
    function automatic logic [11:0] audio_mag(input logic [11:0] s);
        return (s >= AUDIO_MIDSCALE) ? (s - AUDIO_MIDSCALE) : (AUDIO_MIDSCALE - s);
    endfunction

    // Loudness digit 0..9: (peak * 10) >> 11 in 15 bits, clamped at LEVEL_MAX.
    function automatic logic [3:0] audio_level(input logic [11:0] pk);
        logic [3:0] lvl;
        lvl = 4'((15'(pk) * 15'd10) >> 11);
        return (lvl > 4'(LEVEL_MAX)) ? 4'(LEVEL_MAX) : lvl;
    endfunction

endpackage

// File: rtl/spi_adc_reader.sv
// rtl/spi_adc_reader.sv - SPI master for one 16-clock ADC frame per start pulse
//
// Ports:
//   clock, resetn        system clock, asynchronous active-low reset
//   start                begin a frame (ignored unless idle)
//   mic_miso             ADC serial data, asynchronous to clock
//   mic_cs_n, mic_sclk   ADC chip select (active low) and serial clock (idles high)
//   sample               last captured 12-bit sample
//   sample_valid         one-cycle pulse on the first QUIET cycle
module spi_adc_reader
    import mic_capture_pkg::*;
#(
    parameter int SCLK_HALF = 50
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        mic_miso,
    output logic        mic_cs_n,
    output logic        mic_sclk,
    output logic [11:0] sample,
    output logic        sample_valid
);

    localparam int HALF_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

    mic_state_e                 state;
    logic [HALF_W-1:0]          half_cnt;
    logic [3:0]                 bit_cnt;
    // Only the data bits are kept: the four leading bits shift out of the top.
    logic [MIC_DATA_BITS-1:0]   shift;
    logic                       miso_meta;
    logic                       miso_sync;
    logic                       half_done;

    assign half_done = (half_cnt == HALF_W'(SCLK_HALF - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            half_cnt     <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            miso_meta    <= 1'b0;
            miso_sync    <= 1'b0;
            mic_cs_n     <= 1'b1;
            mic_sclk     <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            miso_meta    <= mic_miso;
            miso_sync    <= miso_meta;
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mic_cs_n <= 1'b0;
                        mic_sclk <= 1'b0;
                        half_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= LOW;
                    end
                end
                LOW: begin
                    if (half_done) begin
                        // Capture just before the rising edge, where ADC data is most settled.
                        shift    <= {shift[MIC_DATA_BITS-2:0], miso_sync};
                        mic_sclk <= 1'b1;
                        half_cnt <= '0;
                        state    <= HIGH;
                    end else begin
                        half_cnt <= half_cnt + HALF_W'(1);
                    end
                end
                HIGH: begin
                    if (half_done) begin
                        half_cnt <= '0;
                        if (bit_cnt == 4'(MIC_FRAME_BITS - 1)) begin
                            mic_cs_n     <= 1'b1;
                            sample       <= shift;
                            sample_valid <= 1'b1;
                            state        <= QUIET;
                        end else begin
                            bit_cnt  <= bit_cnt + 4'd1;
                            mic_sclk <= 1'b0;
                            state    <= LOW;
                        end
                    end else begin
                        half_cnt <= half_cnt + HALF_W'(1);
                    end
                end
                QUIET: begin
                    if (half_done) begin
                        half_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        half_cnt <= half_cnt + HALF_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mic_capture.sv
// rtl/mic_capture.sv - microphone ADC capture with windowed peak and 0..9 loudness
//
// Ports:
//   clock, resetn        system clock, asynchronous active-low reset
//   enable               start a conversion on each sample tick
//   mic_miso             ADC serial data
//   mic_cs_n, mic_sclk   ADC chip select and serial clock
//   sample, sample_valid last sample (offset binary) and its update pulse
//   peak                 max |sample - 0x800| over the last completed window (0..2048)
//   level                loudness digit 0..9 derived from peak
//   level_valid          one-cycle pulse when peak and level update
module mic_capture
    import mic_capture_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SAMPLE_HZ   = 20_000,
    parameter int SCLK_HALF   = 50,
    parameter int PEAK_WINDOW = 4000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mic_miso,
    output logic        mic_cs_n,
    output logic        mic_sclk,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic [11:0] peak,
    output logic [3:0]  level,
    output logic        level_valid
);

    localparam int TICK_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WIN_W    = (PEAK_WINDOW > 1) ? $clog2(PEAK_WINDOW) : 1;

    // A whole frame plus its quiet gap must fit between ticks.
    if (33 * SCLK_HALF >= TICK_DIV) begin : g_timing_check
        $error("mic_capture: 33*SCLK_HALF must be below CLK_HZ/SAMPLE_HZ");
    end

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [WIN_W-1:0]  win_cnt;
    logic [11:0]       acc;
    logic [11:0]       mag;
    logic [11:0]       win_max;

    // Free-running so the sample phase survives enable toggling.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
            tick_cnt <= '0;
            tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
            tick     <= 1'b0;
        end
    end

    spi_adc_reader #(
        .SCLK_HALF (SCLK_HALF)
    ) u_reader (
        .clock        (clock),
        .resetn       (resetn),
        .start        (tick & enable),
        .mic_miso     (mic_miso),
        .mic_cs_n     (mic_cs_n),
        .mic_sclk     (mic_sclk),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    always_comb begin
        mag     = audio_mag(sample);
        win_max = (mag > acc) ? mag : acc;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            win_cnt     <= '0;
            acc         <= '0;
            peak        <= '0;
            level       <= '0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            if (sample_valid) begin
                if (win_cnt == WIN_W'(PEAK_WINDOW - 1)) begin
                    win_cnt     <= '0;
                    acc         <= '0;
                    peak        <= win_max;
                    level       <= audio_level(win_max);
                    level_valid <= 1'b1;
                end else begin
                    win_cnt <= win_cnt + WIN_W'(1);
                    acc     <= win_max;
                end
            end
        end
    end

endmodule

// File: tb/tb_mic_capture.sv
// tb/tb_mic_capture.sv - self-checking bench for mic_capture
module tb_mic_capture;

    localparam int CLK_HZ      = 180;
    localparam int SAMPLE_HZ   = 1;
    localparam int SCLK_HALF   = 5;
    localparam int PEAK_WINDOW = 4;
    localparam int PERIOD      = CLK_HZ / SAMPLE_HZ;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        mic_miso = 1'b0;
    logic        mic_cs_n;
    logic        mic_sclk;
    logic [11:0] sample;
    logic        sample_valid;
    logic [11:0] peak;
    logic [3:0]  level;
    logic        level_valid;

    int checks = 0;
    int errors = 0;

    mic_capture #(
        .CLK_HZ      (CLK_HZ),
        .SAMPLE_HZ   (SAMPLE_HZ),
        .SCLK_HALF   (SCLK_HALF),
        .PEAK_WINDOW (PEAK_WINDOW)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .enable       (enable),
        .mic_miso     (mic_miso),
        .mic_cs_n     (mic_cs_n),
        .mic_sclk     (mic_sclk),
        .sample       (sample),
        .sample_valid (sample_valid),
        .peak         (peak),
        .level        (level),
        .level_valid  (level_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- ADC model: shifts a word out MSB first after each SCLK fall
    logic [15:0] tx_q[$];
    logic [11:0] exp_sample_q[$];
    logic [15:0] tx_word = 16'h0000;
    int          tx_idx = 0;
    int          skew;
    bit          rand_frames = 1'b0;

    always @(negedge mic_sclk) begin
        if (tx_idx == 0) begin
            if (tx_q.size() > 0) tx_word = tx_q.pop_front();
            else if (rand_frames) tx_word = 16'($urandom);
            else tx_word = 16'h0800;
            exp_sample_q.push_back(tx_word[11:0]);
        end
        if (tx_idx < 16) begin
            // Junk toggling for 0..2 cycles before the true bit settles.
            skew = $urandom_range(0, 2);
            for (int k = 0; k < skew; k++) begin
                mic_miso = 1'($urandom);
                @(posedge clock);
            end
            #1 mic_miso = tx_word[15 - tx_idx];
            tx_idx++;
        end
    end

    always @(posedge mic_cs_n or negedge resetn) tx_idx = 0;

    // ---------------- Monitor with window reference model
    int          cyc = 0;
    int          cs_falls = 0;
    int          sv_count = 0;
    int          lv_count = 0;
    int          last_fall_cyc = 0;
    int          last_sv_cyc = 0;
    int          fr_rises = 0;
    int          fr_falls = 0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b1;
    logic        prev_sv = 1'b0;
    logic [11:0] win_q[$];
    logic [31:0] exp_peak_q[$];
    logic [31:0] exp_level_q[$];
    logic [11:0] mon_exp;
    logic [31:0] mon_epk;
    logic [31:0] mon_elv;
    int          mon_pk;
    int          mon_m;
    int          mon_lv;

    always @(negedge clock) begin
        cyc++;
        if (!resetn) begin
            prev_cs = 1'b1;
            prev_sclk = 1'b1;
            prev_sv = 1'b0;
            exp_sample_q.delete();
            win_q.delete();
            exp_peak_q.delete();
            exp_level_q.delete();
        end else begin
            if (prev_cs && !mic_cs_n) begin
                cs_falls++;
                last_fall_cyc = cyc;
                fr_rises = 0;
                fr_falls = 0;
            end
            if (prev_sclk && !mic_sclk) fr_falls++;
            if (!prev_sclk && mic_sclk) fr_rises++;
            if (!prev_cs && mic_cs_n) begin
                check("cs_low_cycles", cyc - last_fall_cyc, 32 * SCLK_HALF);
                check("sclk_rises", fr_rises, 16);
                check("sclk_falls", fr_falls, 16);
            end
            if (sample_valid) begin
                check("sv_one_cycle", prev_sv, 0);
                if (exp_sample_q.size() > 0) mon_exp = exp_sample_q.pop_front();
                else mon_exp = 12'hxxx;
                check("sample", sample, mon_exp);
                sv_count++;
                last_sv_cyc = cyc;
                win_q.push_back(mon_exp);
                if (win_q.size() == PEAK_WINDOW) begin
                    mon_pk = 0;
                    foreach (win_q[i]) begin
                        mon_m = (win_q[i] >= 12'h800) ? int'(win_q[i]) - 2048 : 2048 - int'(win_q[i]);
                        if (mon_m > mon_pk) mon_pk = mon_m;
                    end
                    mon_lv = (mon_pk * 10) / 2048;
                    if (mon_lv > 9) mon_lv = 9;
                    exp_peak_q.push_back(mon_pk);
                    exp_level_q.push_back(mon_lv);
                    win_q.delete();
                end
            end
            if (level_valid) begin
                lv_count++;
                check("lv_after_sv", cyc - last_sv_cyc, 1);
                if (exp_peak_q.size() > 0) begin
                    mon_epk = exp_peak_q.pop_front();
                    mon_elv = exp_level_q.pop_front();
                end else begin
                    mon_epk = 'x;
                    mon_elv = 'x;
                end
                check("peak", peak, mon_epk);
                check("level", level, mon_elv);
            end
            prev_cs = mic_cs_n;
            prev_sclk = mic_sclk;
            prev_sv = sample_valid;
        end
    end

    // ---------------- Bounded waits
    task automatic wait_sv(input int n, input int budget, input string tag);
        int start;
        int c;
        start = sv_count;
        c = 0;
        while (sv_count < start + n && c < budget) begin
            @(negedge clock);
            c++;
        end
        check(tag, sv_count - start, n);
    endtask

    task automatic wait_lv(input int n, input int budget, input string tag);
        int start;
        int c;
        start = lv_count;
        c = 0;
        while (lv_count < start + n && c < budget) begin
            @(negedge clock);
            c++;
        end
        check(tag, lv_count - start, n);
    endtask

    task automatic wait_fall(input int budget, input string tag);
        int start;
        int c;
        start = cs_falls;
        c = 0;
        while (cs_falls == start && c < budget) begin
            @(negedge clock);
            c++;
        end
        check(tag, cs_falls - start, 1);
    endtask

    task automatic wait_bit(input int idx, input int budget, input string tag);
        int c;
        c = 0;
        while (tx_idx < idx && c < budget) begin
            @(negedge clock);
            c++;
        end
        check(tag, (tx_idx >= idx), 1);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    logic [11:0] win_words[16];
    int          f0;
    int          sv0;
    int          falls0;

    initial begin
        win_words = '{12'h800, 12'h900, 12'h600, 12'h7FF,
                      12'h123, 12'h000, 12'hFFF, 12'h800,
                      12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
                      12'h800, 12'h800, 12'h800, 12'h800};

        // Reset values
        repeat (2) @(negedge clock);
        check("rst_cs_n", mic_cs_n, 1);
        check("rst_sclk", mic_sclk, 1);
        check("rst_sample", sample, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_peak", peak, 0);
        check("rst_level", level, 0);
        check("rst_level_valid", level_valid, 0);
        resetn = 1'b1;

        // First frame 0x0ABC, and the start-to-start period
        tx_q.push_back(16'h0ABC);
        enable = 1'b1;
        wait_sv(1, 2 * PERIOD, "first_frame_done");
        check("first_sample", sample, 12'hABC);
        f0 = last_fall_cyc;
        wait_fall(2 * PERIOD, "second_frame_start");
        check("frame_spacing", last_fall_cyc - f0, PERIOD);
        wait_sv(1, 2 * PERIOD, "second_frame_done");

        // Four back-to-back windows with a fresh window alignment
        pulse_reset();
        foreach (win_words[i]) tx_q.push_back({4'($urandom), win_words[i]});
        wait_lv(1, 6 * PERIOD, "window1_done");
        check("w1_peak", peak, 12'h200);
        check("w1_level", level, 2);
        wait_lv(1, 6 * PERIOD, "window2_done");
        check("w2_peak_full_scale", peak, 2048);
        check("w2_level_clamped", level, 9);
        wait_lv(1, 6 * PERIOD, "window3_done");
        check("w3_peak", peak, 2047);
        check("w3_level", level, 9);
        wait_lv(1, 6 * PERIOD, "window4_done");
        check("w4_peak", peak, 0);
        check("w4_level", level, 0);

        // enable dropped during bit 5: frame completes, nothing new starts, phase kept
        wait_fall(2 * PERIOD, "en_frame_start");
        f0 = last_fall_cyc;
        wait_bit(6, 2 * PERIOD, "en_reach_bit5");
        enable = 1'b0;
        wait_sv(1, 2 * PERIOD, "en_frame_completes");
        falls0 = cs_falls;
        repeat (3 * PERIOD) @(negedge clock);
        check("no_frame_while_disabled", cs_falls - falls0, 0);
        enable = 1'b1;
        wait_fall(2 * PERIOD, "reenable_start");
        check("tick_phase_kept", (last_fall_cyc - f0) % PERIOD, 0);

        // Build a nonzero peak, then reset during bit 10
        repeat (8) tx_q.push_back(16'h0F00);
        wait_sv(8, 10 * PERIOD, "loud_frames_done");
        check("loud_peak", peak, 12'h700);
        wait_fall(2 * PERIOD, "abort_frame_start");
        wait_bit(11, 2 * PERIOD, "abort_reach_bit10");
        repeat (2) @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        check("async_cs_n", mic_cs_n, 1);
        check("async_sclk", mic_sclk, 1);
        check("async_sample", sample, 0);
        check("async_sample_valid", sample_valid, 0);
        check("async_peak", peak, 0);
        check("async_level", level, 0);
        check("async_level_valid", level_valid, 0);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        sv0 = sv_count;
        repeat (PERIOD - 10) @(negedge clock);
        check("no_sv_from_aborted", sv_count - sv0, 0);
        wait_sv(1, 2 * PERIOD, "clean_frame_after_reset");

        // Random words with skewed, glitchy data
        rand_frames = 1'b1;
        wait_sv(200, 202 * PERIOD, "random_frames");
        enable = 1'b0;
        repeat (2 * PERIOD) @(negedge clock);
        check("no_leftover_frames", exp_sample_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
